seq_shift_add_multiplier: RTL and testbench
===========================================

// Module: seq_shift_add_multiplier
// PURPOSE
// - Sequential unsigned shift-and-add multiplier; the inverse datapath of the restoring divider.
// - Produces product = multiplicand * multiplier over WIDTH iterations using a start/busy/done handshake.
// - Lets a mul/div arithmetic unit check quotient*divisor+remainder == dividend in-system.
// - Trades throughput for area: one adder of WIDTH bits, reused for WIDTH cycles.
// PARAMETERS
// - WIDTH  4  operand width in bits; product is 2*WIDTH bits; legal range >= 2.
// PORTS
// - clk           input   1        rising-edge clock; sole clock domain
// - rst_n         input   1        synchronous reset, active-low
// - start         input   1        request; sampled only while busy=0
// - multiplicand  input   WIDTH    unsigned operand A; captured on accepted start
// - multiplier    input   WIDTH    unsigned operand B; captured on accepted start
// - busy          output  1        high while iterating; start ignored
// - done          output  1        single-cycle pulse; product valid
// - product       output  2*WIDTH  A*B; held from done until next accepted start completes
// BEHAVIOUR
// - Reset: rst_n low at a rising edge gives state=IDLE, busy=0, done=0, product=0, count=0 and clears all internal registers.
// - Reset during RUN aborts the operation. No done pulse is issued for the aborted operation.
// - States:
//   - IDLE: start=1 goes to RUN.
//   - RUN: loops for WIDTH cycles, then goes to DONE.
//   - DONE: lasts one cycle. Goes to RUN if start=1, otherwise to IDLE.
// - Accept: at an edge where busy=0 and start=1:
//   - M <- multiplicand, Q <- multiplier, ACC <- 0 (WIDTH+1 bits, holds carry), count <- 0.
// - RUN iteration, once per cycle:
//   - sum = ACC[WIDTH-1:0] + (Q[0] ? M : 0), computed WIDTH+1 bits wide.
//   - {ACC,Q} <- {1'b0, sum, Q} >> 1, i.e. ACC <- sum >> 1 and Q <- {sum[0], Q[WIDTH-1:1]}.
//   - count++. Leave RUN when count == WIDTH-1.
// - Latency:
//   - Start accepted at edge k.
//   - busy=1 during cycles k+1 .. k+WIDTH.
//   - done=1 and product={ACC[WIDTH-1:0],Q} registered in cycle k+WIDTH+1.
//   - Latency is fixed; zero operands do not shorten it.
// - busy is low in IDLE and DONE. Back-to-back: start held high gives one result every WIDTH+1 cycles.
// - Operands are don't-care after the accept edge. Changes while busy have no effect.
// - product changes only at the edge where done rises. It is never partially updated.
// - Arithmetic is unsigned. A 2*WIDTH-bit product cannot overflow.
// - Max case: (2^W-1)^2 fits. For W=4, 15*15=225=8'hE1.
// - done and busy are never high in the same cycle.
// - X on start while busy=1 must not disturb state.
// STRUCTURE
// - Shared package arith_pkg:
//   - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 unreachable, recovers to IDLE).
//   - function clog2 for sizing count: max(1, clog2(WIDTH)) bits.
// - Single module: FSM + count + M/Q/ACC registers + one WIDTH-bit adder.
// - No sub-module. The adder is an inline expression.
// TESTING (WIDTH=4, check busy/done timing and product every cycle)
// - Four sequential operations, each start=1 for one cycle:
//   - 15*3 -> done at k+5, product=45.
//   - 14*3 -> done at k+5, product=42.
//   - 13*5 -> done at k+5, product=65.
//   - 9*2 -> done at k+5, product=18.
// - Corners:
//   - 15*15 -> product=225.
//   - 0*13 -> product=0.
//   - 7*0 -> product=0.
//   - All three still take exactly 5 cycles.
// - start pulsed with 6*6 while busy (k+2) -> ignored. Product of the first op correct. Only one done pulse.
// - start held high with operand stream 2*3, 4*5 -> done pulses 5 cycles apart with products 6 then 20. busy=0 in done cycles.
// - rst_n=0 at k+3 mid-op -> next cycle busy=0, done=0, product=0. No done appears later. Fresh 9*2 gives 18.
// - Exhaustive sweep of all 256 operand pairs vs reference model a*b. Zero mismatches.

Source files
------------

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared state encoding and sizing helper for the iterative arithmetic units
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier, one adder reused WIDTH cycles
module seq_shift_add_multiplier
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (clog2(WIDTH) > 1) ? clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     q_q, q_d;
    // The adder carry is shifted down in the same step, so the stored accumulator never needs it.
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     acc_shift;
    logic [WIDTH-1:0]     q_shift;
    logic                 accept;

    always_comb begin
        sum       = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        acc_shift = sum[WIDTH:1];
        q_shift   = {sum[0], q_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        product_d = product_q;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                accept  = start;
            end
            ST_RUN: begin
                acc_d   = acc_shift;
                q_d     = q_shift;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    state_d   = ST_DONE;
                    product_d = {acc_shift, q_shift};
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            state_d = ST_RUN;
            m_d     = multiplicand;
            q_d     = multiplier;
            acc_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            m_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - scoreboard bench for seq_shift_add_multiplier
module tb_seq_shift_add_multiplier;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    always #5 clk = ~clk;

    seq_shift_add_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (a),
        .multiplier   (b),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    typedef struct {
        logic [2*W-1:0] prod;
        int             dcyc;
    } exp_t;

    exp_t           sb[$];
    int             cyc = 0;
    int             total = 0;
    int             bad = 0;
    logic           checking = 1'b0;
    logic [2*W-1:0] last_prod = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s at cycle %0d: got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // Expected busy window and done cycle both derive from the accept cycle recorded at issue.
    always @(negedge clk) begin
        logic exp_done;
        logic exp_busy;
        if (checking) begin
            exp_done = (sb.size() > 0) && (sb[0].dcyc == cyc);
            exp_busy = (sb.size() > 0) && (cyc >= sb[0].dcyc - W) && (cyc < sb[0].dcyc);
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                chk("product", 32'(product), 32'(sb[0].prod));
                last_prod = sb[0].prod;
                void'(sb.pop_front());
            end else begin
                chk("product_hold", 32'(product), 32'(last_prod));
            end
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] e);
        exp_t item;
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        item.prod = e;
        item.dcyc = cyc + W;
        sb.push_back(item);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 40) begin
            @(negedge clk);
            n = n + 1;
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    logic [W-1:0]   ta [7] = '{4'd15, 4'd14, 4'd13, 4'd9, 4'd15, 4'd0,  4'd7};
    logic [W-1:0]   tb [7] = '{4'd3,  4'd3,  4'd5,  4'd2, 4'd15, 4'd13, 4'd0};
    logic [2*W-1:0] tp [7] = '{8'd45, 8'd42, 8'd65, 8'd18, 8'd225, 8'd0, 8'd0};

    initial begin
        exp_t item;
        @(posedge clk);
        #1;
        checking = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            issue(ta[i], tb[i], tp[i]);
            drain();
        end

        // A start pulse while busy must be ignored: one done, first operands' product.
        issue(4'd15, 4'd3, 8'd45);
        @(negedge clk);
        start = 1'b1;
        a     = 4'd6;
        b     = 4'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (8) @(negedge clk);

        // start held high: the DONE cycle accepts the next pair.
        issue(4'd2, 4'd3, 8'd6);
        start = 1'b1;
        a     = 4'd4;
        b     = 4'd5;
        repeat (W) @(posedge clk);
        @(posedge clk);
        #1;
        item.prod = 8'd20;
        item.dcyc = cyc + W;
        sb.push_back(item);
        start = 1'b0;
        drain();

        // Reset mid-operation aborts it with no done pulse.
        issue(4'd14, 4'd3, 8'd42);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        last_prod = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        issue(4'd9, 4'd2, 8'd18);
        drain();

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                issue(W'(i), W'(j), (2*W)'(i * j));
                drain();
            end
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
